// File: rtl/alu_exec_unit.sv
// alu_exec_unit: sequential execution wrapper around an 8-bit ALU datapath.
//
// One operation is in flight at a time.
// - ADD, SUB, NOR, NAND, SLTU and SLT finish at the accept edge (latency 1).
// - SLL, SRL and SRA run one bit per cycle (latency 1 + shift amount).
//
// Handshakes: both channels transfer on a rising edge where valid && ready.
// - in_ready is high only in IDLE, and only while rst_n is released.
// - out_valid is high only in DONE.
// - Once out_valid is high, out_result and the status flags hold stable
//   until the consumer takes them with out_ready.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         request channel
//   in_a, in_b                  operands; in_b is also the shift amount
//   in_ctrl, in_flag            operation select and variant
//   out_valid / out_ready       response channel
//   out_result                  result
//   out_overflow                signed overflow (ADD/SUB)
//   out_carry                   ADD carry out, SUB borrow
//   out_zero                    result is zero
//   out_err                     reserved ctrl code was issued
module alu_exec_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_ctrl,
    input  logic             in_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0]   SH_SLL   = 2'd0;
    localparam logic [1:0]   SH_SRL   = 2'd1;
    localparam logic [1:0]   SH_SRA   = 2'd2;
    localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [SHW:0]     cnt;
    logic [1:0]       sh_kind;

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic             alu_carry;
    logic             alu_err;
    logic             is_shift;
    logic [1:0]       sh_sel;
    logic [SHW:0]     shamt;
    logic [WIDTH-1:0] work_shifted;

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Any set bit of b above the shift field saturates the count at WIDTH.
    // Shifting by WIDTH already empties the word or fills it with sign bits.
    assign shamt = (|(in_b >> SHW)) ? CNT_FULL : {1'b0, in_b[SHW-1:0]};

    // Single-cycle datapath. It reads the live inputs, so it is only
    // meaningful at the accept edge.
    always_comb begin
        sum        = {1'b0, in_a} + {1'b0, in_b};
        diff       = {1'b0, in_a} - {1'b0, in_b};
        alu_result = '0;
        alu_ovf    = 1'b0;
        alu_carry  = 1'b0;
        alu_err    = 1'b0;
        is_shift   = 1'b0;
        sh_sel     = SH_SLL;
        case (in_ctrl)
            3'b000: begin
                if (!in_flag) begin
                    alu_result = sum[WIDTH-1:0];
                    alu_carry  = sum[WIDTH];
                    alu_ovf    = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                                 (sum[WIDTH-1] != in_a[WIDTH-1]);
                end else begin
                    alu_result = diff[WIDTH-1:0];
                    alu_carry  = diff[WIDTH];    // borrow: a < b unsigned
                    alu_ovf    = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                                 (diff[WIDTH-1] != in_a[WIDTH-1]);
                end
            end
            3'b001: alu_result = in_flag ? ~(in_a & in_b) : ~(in_a | in_b);
            3'b010: alu_result[0] = in_flag ? ($signed(in_a) < $signed(in_b))
                                            : (in_a < in_b);
            3'b011: begin
                is_shift = 1'b1;
                sh_sel   = in_flag ? SH_SLL : SH_SRL;
            end
            3'b100: begin
                is_shift = 1'b1;
                sh_sel   = SH_SRA;
            end
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        case (sh_kind)
            SH_SLL:  work_shifted = {work[WIDTH-2:0], 1'b0};
            SH_SRL:  work_shifted = {1'b0, work[WIDTH-1:1]};
            default: work_shifted = {work[WIDTH-1], work[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (is_shift && (shamt != '0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            work         <= '0;
            cnt          <= '0;
            sh_kind      <= SH_SLL;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_carry    <= 1'b0;
            out_zero     <= 1'b0;
            out_err      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift) begin
                            work         <= in_a;
                            cnt          <= shamt;
                            sh_kind      <= sh_sel;
                            out_overflow <= 1'b0;
                            out_carry    <= 1'b0;
                            out_err      <= 1'b0;
                            // A zero shift amount skips SHIFT entirely.
                            if (shamt == '0) begin
                                out_result <= in_a;
                                out_zero   <= (in_a == '0);
                            end
                        end else begin
                            out_result   <= alu_result;
                            out_overflow <= alu_ovf;
                            out_carry    <= alu_carry;
                            out_zero     <= (alu_result == '0);
                            out_err      <= alu_err;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_shifted;
                    cnt  <= cnt - CNT_ONE;
                    // The last step publishes the result together with the
                    // move to DONE.
                    if (cnt == CNT_ONE) begin
                        out_result <= work_shifted;
                        out_zero   <= (work_shifted == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequential execution wrapper for the Octa16 8-bit ALU datapath. It accepts one operation at a time (a, b, ctrl, flag) over a valid/ready request channel.
- Add, subtract, logic and compare complete in a single cycle. Shifts run iteratively, one bit per cycle.
- Each result returns with status flags over a valid/ready response channel.
- It sits between the instruction decode/issue stage and writeback, replacing direct combinational ALU use where operand capture and back-pressure are required.

Parameters:
- WIDTH, 8, datapath width of a, b and result.
- SHW, 3, shift-amount field width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b; also the shift amount for shift ops.
- in_ctrl  input  3  operation select.
- in_flag  input  1  operation variant select.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  result.
- out_overflow  output  1  signed overflow (ADD/SUB only, else 0).
- out_carry  output  1  ADD: carry out; SUB: borrow (a<b unsigned); else 0.
- out_zero  output  1  out_result == 0.
- out_err  output  1  reserved ctrl code was issued.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - out_valid, out_result, out_overflow, out_carry, out_zero and out_err all 0.
  - in_ready goes to 1 once rst_n deasserts.
- Accept: a request is accepted when in_valid && in_ready on a rising edge. Operands and op are registered at accept; input changes after that have no effect.
- Operation decode:
  - ctrl 000: flag 0 = ADD (a+b), flag 1 = SUB (a-b), both modulo 2^WIDTH.
  - ctrl 001: flag 0 = NOR, flag 1 = NAND.
  - ctrl 010: flag 0 = SLTU (unsigned a<b), flag 1 = SLT (signed). Result is 1 or 0, zero-extended.
  - ctrl 011: flag 1 = SLL, flag 0 = SRL.
  - ctrl 100: SRA; flag is ignored.
  - ctrl 101/110/111: reserved. out_result = 0, out_err = 1, out_zero = 1, other flags 0.
- Overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from a.
- States: IDLE, SHIFT, DONE.
  - IDLE -> DONE on accepting a non-shift op. The result is registered at the accept edge, so out_valid is high in the following cycle (latency 1).
  - IDLE -> SHIFT on accepting a shift op.
    - Working register = a; counter = shamt.
    - shamt = WIDTH if any bit of b above SHW is set; otherwise b[SHW-1:0].
    - Each SHIFT cycle shifts by 1 and decrements the counter.
    - SHIFT -> DONE on the edge where the counter reaches 0.
    - shamt = 0 goes straight to DONE with result = a.
    - Total latency from accept to out_valid = 1 + shamt cycles.
  - SRA fills with a[WIDTH-1]. SLL and SRL fill with 0. Shifting by WIDTH or more gives 0 (SLL/SRL) or all sign bits (SRA).
  - DONE: out_valid = 1 and outputs are held stable until out_valid && out_ready. On that edge the state returns to IDLE and out_valid drops.
- Throughput: in_ready is 0 in SHIFT and DONE, so at most one op is in flight. A new request can be accepted the cycle after the response handshake; there is no same-cycle bypass.
- Reset mid-operation (rst_n asserted in SHIFT or DONE): the in-flight op is discarded, outputs clear immediately, and no response is produced.

Test Plan:
- Reset with in_valid = 1 held → in_ready = 0 and out_valid = 0 while rst_n is low. Deassert rst_n → in_ready = 1 and the op is accepted on the first edge.
- ADD, a=0x0F, b=0x0A → out_result = 0x19, overflow 0, carry 0, out_valid one cycle after accept. ADD, a=0x82, b=0x82 → out_result = 0x04, overflow 1, carry 1.
- SUB, a=0x0A, b=0x0F → out_result = 0xFB, carry (borrow) 1, overflow 0. SUB, a=0x0F, b=0x0A → out_result = 0x05.
- Logic/compare, a=0xAA, b=0xCC:
  - NOR → 0x11.
  - NAND → 0x77.
  - SLTU with a=0x0A, b=0x14 → 0x01.
  - SLT with a=0x80, b=0x01 → 0x01.
  - ctrl=101 → out_result = 0x00, out_err = 1.
- Shifts:
  - SLL 0x0F by 2 → 0x3C, out_valid exactly 3 cycles after accept.
  - SRL 0xF0 by 2 → 0x3C.
  - SRA 0xF0 by 2 → 0xFC.
  - SRA 0x80 by b=0x09 → 0xFF after 9 cycles.
  - SLL by 0 → a unchanged, latency 1.
- Back-pressure: hold out_ready = 0 for 5 cycles in DONE → outputs stable and in_ready = 0. Assert rst_n = 0 during a SHIFT → out_valid never rises and in_ready = 1 after release.
